if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with an internal prefetch queue, sitting between EX/MEM (jump, memory-port arbitration), the I-cache and the IF_ID latch. It keeps a fetch PC and issues one outstanding I-cache request at a time. It buffers returned instructions in a DEPTH-entry FIFO so IF_ID can be fed one instruction per cycle while the cache is busy. On a jump it flushes the queue and discards any in-flight response.

---
 rtl/if_prefetch.sv | 169 ++++++++++++++++
 tb/tb_if_prefetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue between the I-cache and IF_ID.
// One I-cache request outstanding at a time; a jump flushes the queue and drops any in-flight response.
module if_prefetch #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          INST_W    = 32,
    parameter int unsigned          ICACHE_AW = 18,
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          STALL_W   = 6,
    parameter int unsigned          PC_STEP   = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC  = {ADDR_W{1'b0}}
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [STALL_W-1:0]      stall_in,
    input  logic                    pcJump_in,
    input  logic [ADDR_W-1:0]       pcTarget_in,
    input  logic                    MEM_MCAccess_in,
    input  logic                    instE_in,
    input  logic [INST_W-1:0]       inst_in,
    output logic                    ICache_out,
    output logic [ICACHE_AW-1:0]    ICacheAddr_out,
    output logic                    instE_out,
    output logic [ADDR_W-1:0]       IF_pc_out,
    output logic [INST_W-1:0]       inst_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] req_pc_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [INST_W-1:0] inst_mem_r [DEPTH];

    logic out_valid_s;
    logic pop_s;
    logic push_s;
    logic issue_s;
    logic unused_s;

    // Only the IF_ID-accept stall bit and the word-aligned part of the target matter here.
    assign unused_s = ^{stall_in[STALL_W-1:1], pcTarget_in[1:0]};

    assign out_valid_s = (count_r != {CNT_W{1'b0}}) && !pcJump_in;
    assign pop_s       = out_valid_s && !stall_in[0] && rdy_in;
    assign push_s      = (state_r == ST_WAIT) && instE_in && !pcJump_in;

    // Occupancy after this edge; a new request is only allowed if its response will fit.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    assign issue_s = ((state_r == ST_IDLE) || push_s) && (count_nxt_s < DEPTH_C)
                     && !MEM_MCAccess_in && !pcJump_in;

    // Request FSM next state; a jump with a response still pending must swallow it in DROP.
    always_comb begin
        state_nxt_s = state_r;
        if (pcJump_in) begin
            if (((state_r == ST_WAIT) || (state_r == ST_DROP)) && !instE_in) begin
                state_nxt_s = ST_DROP;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (instE_in) begin
                        state_nxt_s = issue_s ? ST_WAIT : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (instE_in) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM state and fetch/request PCs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= {ADDR_W{1'b0}};
        end else if (rdy_in) begin
            state_r <= state_nxt_s;
            if (pcJump_in) begin
                fetch_pc_r <= {pcTarget_in[ADDR_W-1:2], 2'b00};
            end else if (issue_s) begin
                req_pc_r   <= fetch_pc_r;
                fetch_pc_r <= fetch_pc_r + ADDR_W'(PC_STEP);
            end
        end
    end

    // Queue pointers and occupancy; a jump empties the queue.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (rdy_in) begin
            if (pcJump_in) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                count_r <= count_nxt_s;
            end
        end
    end

    // Queue storage: each entry pairs a returned instruction with the PC it was fetched from.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_r[i]   <= {ADDR_W{1'b0}};
                inst_mem_r[i] <= {INST_W{1'b0}};
            end
        end else if (rdy_in && push_s) begin
            pc_mem_r[wr_ptr_r]   <= req_pc_r;
            inst_mem_r[wr_ptr_r] <= inst_in;
        end
    end

    assign ICache_out     = (state_r != ST_IDLE);
    assign ICacheAddr_out = ICache_out ? req_pc_r[ICACHE_AW-1:0] : {ICACHE_AW{1'b0}};
    assign instE_out      = out_valid_s;
    assign IF_pc_out      = out_valid_s ? pc_mem_r[rd_ptr_r] : {ADDR_W{1'b0}};
    assign inst_out       = out_valid_s ? inst_mem_r[rd_ptr_r] : {INST_W{1'b0}};

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a behavioural cache plus a queue-based reference model.
module tb_if_prefetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [5:0]  stall_in;
    logic        pcJump_in;
    logic [31:0] pcTarget_in;
    logic        MEM_MCAccess_in;
    logic        instE_in;
    logic [31:0] inst_in;
    logic        ICache_out;
    logic [17:0] ICacheAddr_out;
    logic        instE_out;
    logic [31:0] IF_pc_out;
    logic [31:0] inst_out;

    if_prefetch dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
        .pcJump_in(pcJump_in), .pcTarget_in(pcTarget_in), .MEM_MCAccess_in(MEM_MCAccess_in),
        .instE_in(instE_in), .inst_in(inst_in), .ICache_out(ICache_out),
        .ICacheAddr_out(ICacheAddr_out), .instE_out(instE_out), .IF_pc_out(IF_pc_out),
        .inst_out(inst_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    int errors = 0;
    int checks = 0;

    // reference model: delivered-but-unconsumed instructions, one pending request, discard flag
    ent_t        q[$];
    bit          m_out;
    bit          m_disc;
    logic [31:0] m_req;
    logic [31:0] m_fetch;

    // cache model
    int lat;
    int age;
    bit force_resp;

    // expected outputs for the current cycle
    bit          e_v;
    bit          e_req;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [17:0] e_addr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        q.delete();
        m_out = 1'b0;
        m_disc = 1'b0;
        m_req = 32'h0;
        m_fetch = 32'h0;
        age = 0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0; rdy_in = 1'b1; stall_in = 6'h0; pcJump_in = 1'b0;
        pcTarget_in = 32'h0; MEM_MCAccess_in = 1'b0; instE_in = 1'b0; inst_in = 32'h0;
        force_resp = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        model_reset();
        rst_in = 1'b1;
    endtask

    // Drive one cycle of inputs (called just after a rising edge) and derive expected outputs.
    task automatic apply(input bit jmp, input logic [31:0] tgt, input bit mem, input bit stl, input bit rdy);
        pcJump_in = jmp;
        pcTarget_in = tgt;
        MEM_MCAccess_in = mem;
        stall_in = {5'($urandom), stl};
        rdy_in = rdy;
        instE_in = force_resp || (rdy && ICache_out && (age >= lat));
        inst_in = (instE_in && ICache_out) ? mem_fn({14'b0, ICacheAddr_out}) : $urandom;
        #2;
        e_v = (q.size() != 0) && !jmp;
        e_pc = e_v ? q[0].pc : 32'h0;
        e_inst = e_v ? q[0].inst : 32'h0;
        e_req = m_out;
        e_addr = m_out ? m_req[17:0] : 18'h0;
    endtask

    // Advance one clock edge and update the reference model from the rules of the stage.
    task automatic tick();
        bit   c_req;
        bit   resp;
        bit   pop;
        bit   push;
        bit   was_idle;
        ent_t e;
        c_req = ICache_out;
        @(posedge clk_in);
        if (rdy_in) begin
            resp = instE_in;
            age = (c_req && !resp) ? age + 1 : 0;
            if (pcJump_in) begin
                q.delete();
                m_fetch = {pcTarget_in[31:2], 2'b00};
                if (m_out && !resp) m_disc = 1'b1;
                else begin m_out = 1'b0; m_disc = 1'b0; end
            end else begin
                was_idle = !m_out;
                pop = (q.size() != 0) && !stall_in[0];
                push = m_out && resp && !m_disc;
                if (m_out && resp) begin m_out = 1'b0; m_disc = 1'b0; end
                if (pop) void'(q.pop_front());
                if (push) begin
                    e.pc = m_req;
                    e.inst = mem_fn(m_req & 32'h0003_FFFF);
                    q.push_back(e);
                end
                if ((was_idle || push) && (q.size() < 4) && !MEM_MCAccess_in) begin
                    m_out = 1'b1;
                    m_req = m_fetch;
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_in = 1'b0;
        instE_in = 1'b1;
        #2;
        checks++;
        if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== 84'h0) begin
            errors++;
            $display("FAIL reset v=%b pc=%h inst=%h req=%b addr=%h required all zero",
                     instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out);
        end
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== {e_v, e_pc, e_inst, e_req, e_addr}) begin
                errors++;
                $display("FAIL stream cyc=%0d got v=%b pc=%h inst=%h req=%b addr=%h exp v=%b pc=%h inst=%h req=%b addr=%h",
                         i, instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out, e_v, e_pc, e_inst, e_req, e_addr);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 0;
        for (int i = 0; i < 18; i++) begin
            apply(1'b0, 32'h0, 1'b0, (i < 10), 1'b1);
            checks++;
            if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== {e_v, e_pc, e_inst, e_req, e_addr}) begin
                errors++;
                $display("FAIL stall cyc=%0d got v=%b pc=%h inst=%h req=%b addr=%h exp v=%b pc=%h inst=%h req=%b addr=%h",
                         i, instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out, e_v, e_pc, e_inst, e_req, e_addr);
            end
            if (i == 9) begin
                checks++;
                if (ICache_out !== 1'b0 || IF_pc_out !== 32'h0) begin
                    errors++;
                    $display("FAIL stall_full req=%b head=%h required req=0 head=00000000", ICache_out, IF_pc_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_jump();
        bit jumped = 1'b0;
        bit jmp;
        bit seen_target = 1'b0;
        do_reset();
        lat = 3;
        for (int i = 0; i < 40; i++) begin
            jmp = !jumped && m_out && (m_req == 32'h8) && (age == 1);
            apply(jmp, 32'h0000_0102, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== {e_v, e_pc, e_inst, e_req, e_addr}) begin
                errors++;
                $display("FAIL jump cyc=%0d got v=%b pc=%h inst=%h req=%b addr=%h exp v=%b pc=%h inst=%h req=%b addr=%h",
                         i, instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out, e_v, e_pc, e_inst, e_req, e_addr);
            end
            if (jumped && instE_out && IF_pc_out == 32'h8) begin
                errors++;
                $display("FAIL jump_drop cyc=%0d pc=%h required dropped response never presented", i, IF_pc_out);
            end
            if (jumped && ICache_out && ICacheAddr_out == 18'h100) seen_target = 1'b1;
            if (jmp) jumped = 1'b1;
            tick();
        end
        checks++;
        if (!jumped || !seen_target) begin
            errors++;
            $display("FAIL jump_target jumped=%b seen=%b required 1 1", jumped, seen_target);
        end
    endtask

    task automatic test_mem();
        bit mem;
        do_reset();
        lat = 2;
        for (int i = 0; i < 24; i++) begin
            mem = (i < 5) || (i >= 7 && i < 12);
            apply(1'b0, 32'h0, mem, 1'b0, 1'b1);
            checks++;
            if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== {e_v, e_pc, e_inst, e_req, e_addr}) begin
                errors++;
                $display("FAIL mem cyc=%0d got v=%b pc=%h inst=%h req=%b addr=%h exp v=%b pc=%h inst=%h req=%b addr=%h",
                         i, instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out, e_v, e_pc, e_inst, e_req, e_addr);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        #3;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== 84'h0) begin
            errors++;
            $display("FAIL reset_mid v=%b pc=%h inst=%h req=%b addr=%h required all zero",
                     instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out);
        end
        @(posedge clk_in);
        #1;
        model_reset();
        rst_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            force_resp = (i == 0);
            apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== {e_v, e_pc, e_inst, e_req, e_addr}) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got v=%b pc=%h inst=%h req=%b addr=%h exp v=%b pc=%h inst=%h req=%b addr=%h",
                         i, instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out, e_v, e_pc, e_inst, e_req, e_addr);
            end
            tick();
        end
        force_resp = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (i % 50 == 0) lat = $urandom_range(0, 3);
            apply(($urandom % 20) == 0, $urandom, ($urandom % 5) == 0, ($urandom % 2) == 0, ($urandom % 8) != 0);
            checks++;
            if ({instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out} !== {e_v, e_pc, e_inst, e_req, e_addr}) begin
                errors++;
                $display("FAIL random cyc=%0d got v=%b pc=%h inst=%h req=%b addr=%h exp v=%b pc=%h inst=%h req=%b addr=%h",
                         i, instE_out, IF_pc_out, inst_out, ICache_out, ICacheAddr_out, e_v, e_pc, e_inst, e_req, e_addr);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_mem();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
